// File: rtl/ones_gen_pkg.sv
// rtl/ones_gen_pkg.sv - shared state encoding and default sizes for the ones generator
package ones_gen_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CW    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/ones_gen_ctrl.sv
// rtl/ones_gen_ctrl.sv - IDLE/SHIFT/DONE sequencer driving the ones generator datapath
module ones_gen_ctrl
    import ones_gen_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_start,
    input  logic i_c_zero,
    output logic o_load,
    output logic o_shift,
    output logic o_dec,
    output logic o_done,
    output logic o_busy
);

    state_t r_state;
    logic   r_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (i_start) r_state <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (i_c_zero) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Start is only honoured in IDLE, so requests during a run are dropped
    assign o_load  = (r_state == ST_IDLE) && i_start;
    assign o_shift = (r_state == ST_SHIFT) && !i_c_zero;
    assign o_dec   = o_shift;
    assign o_done  = r_done;
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: rtl/ones_gen.sv
// rtl/ones_gen.sv - builds a thermometer word of min(K,WIDTH) ones, tri-stated onto Data
module ones_gen
    import ones_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = DEF_CW
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [CW-1:0]    K,
    input  logic             Out,
    output logic [WIDTH-1:0] Data,
    output logic             Busy,
    output logic             Done,
    output logic             Nfull,
    output logic             N0
);

    localparam logic [CW-1:0] W_CW = CW'(WIDTH);

    logic [WIDTH-1:0] r_n;
    logic [CW-1:0]    r_c;
    logic [CW-1:0]    w_k_clamp;
    logic             w_load;
    logic             w_shift;
    logic             w_dec;
    logic             w_c_zero;

    assign w_k_clamp = (K > W_CW) ? W_CW : K;
    assign w_c_zero  = (r_c == '0);

    ones_gen_ctrl u_ctrl (
        .i_clk    (Clock),
        .i_rst_n  (Reset),
        .i_start  (Start),
        .i_c_zero (w_c_zero),
        .o_load   (w_load),
        .o_shift  (w_shift),
        .o_dec    (w_dec),
        .o_done   (Done),
        .o_busy   (Busy)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_n <= '0;
            r_c <= '0;
        end else if (w_load) begin
            r_n <= '0;
            r_c <= w_k_clamp;
        end else begin
            if (w_shift) r_n <= {r_n[WIDTH-2:0], 1'b1};
            if (w_dec)   r_c <= r_c - CW'(1);
        end
    end

    assign Nfull = &r_n;
    assign N0    = r_n[0];
    assign Data  = Out ? r_n : {WIDTH{1'bz}};

endmodule
